pipeline_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three hazard sources into one set of pipeline-register write-enables, bubble selects and flushes:
  - load-use hazards (ID vs EX),
  - taken branches resolved in EX,
  - multi-cycle data-memory waits in MEM.
- Holds a small FSM for memory-wait tracking, a pending-flush latch, a wait watchdog and saturating performance counters.

---
 rtl/pipeline_stall_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for a 5-stage RISC-V pipeline. It merges
// three hazard sources (load-use in ID/EX, taken branches resolved in EX and
// multi-cycle data-memory waits in MEM) into one set of pipeline-register
// write-enables, bubble selects and flushes. It also keeps a memory-wait FSM,
// a pending-flush latch, a wait watchdog and saturating performance counters.
//
// Ports
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous active-high reset
//   IDEX_MemRead   in   EX instruction is a load
//   IDEX_rd        in   EX destination register
//   IFID_rs1/rs2   in   ID source registers
//   branch_taken   in   EX branch/jump redirects the PC (single-cycle pulse)
//   dmem_req       in   MEM stage holds a load/store
//   dmem_ready     in   data memory completes the access this cycle
//   PCWrite        out  PC updates
//   IFID_Write     out  IF/ID loads
//   IFID_Flush     out  IF/ID loads a NOP
//   IDEX_mux_out   out  0 = ID/EX control zeroed (bubble)
//   IDEX_Write     out  ID/EX loads
//   EXMEM_Write    out  EX/MEM loads
//   MEMWB_Bubble   out  MEM/WB loads zero control
//   stall_cnt      out  saturating count of cycles with PCWrite=0
//   flush_cnt      out  saturating count of cycles with IFID_Flush=1
//   mem_timeout    out  sticky memory-wait watchdog flag
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_mux_out,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               flush_pending_q, flush_pending_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               mem_stall_s;
    logic               load_use_s;
    logic               redirect_s;

    assign mem_stall_s = dmem_req & ~dmem_ready;
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use_s  = IDEX_MemRead & (IDEX_rd != 5'd0) &
                         ((IDEX_rd == IFID_rs1) | (IDEX_rd == IFID_rs2));
    assign redirect_s  = branch_taken | flush_pending_q;

    // State register and all registered bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            flush_pending_q <= 1'b0;
            wait_cnt_q      <= '0;
            mem_timeout_q   <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            wait_cnt_q      <= wait_cnt_d;
            mem_timeout_q   <= mem_timeout_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    // Next-state logic: memory-wait FSM, watchdog and pending flush.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
                if (mem_stall_s) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        // The watchdog only reports; the stall itself is never broken.
        if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
            mem_timeout_d = 1'b1;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end
        // A branch seen while MEM stalls is remembered until the stall ends;
        // any cycle without a memory stall either performs the flush or has
        // nothing pending, so the latch clears.
        if (mem_stall_s) begin
            flush_pending_d = flush_pending_q | branch_taken;
        end else begin
            flush_pending_d = 1'b0;
        end
    end

    // Output logic: prioritised hazard resolution into stage controls.
    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_mux_out = 1'b1;
        IDEX_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        MEMWB_Bubble = 1'b0;
        if (reset) begin
            PCWrite      = 1'b1;
        end else if (mem_stall_s) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else if (redirect_s) begin
            // ID holds a wrong-path instruction, so a load-use match is moot.
            IFID_Flush   = 1'b1;
            IDEX_mux_out = 1'b0;
        end else if (load_use_s) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_mux_out = 1'b0;
        end else begin
            PCWrite      = 1'b1;
        end
    end

    // Saturating performance counters, driven by this cycle's controls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PCWrite && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (IFID_Flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pipeline_stall_ctrl. A behavioural model tracks the
// pipeline-level meaning of the inputs (is memory stalling, is a flush owed,
// how long has the wait lasted, how many stall/flush cycles so far) and a
// negedge process compares every DUT output against it each cycle. Directed
// literal checks pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int CNT_W    = 16;
    localparam int MAX_WAIT = 15;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_rd;
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_mux_out;
    logic             IDEX_Write;
    logic             EXMEM_Write;
    logic             MEMWB_Bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    int checks   = 0;
    int failures = 0;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_rd      (IDEX_rd),
        .IFID_rs1     (IFID_rs1),
        .IFID_rs2     (IFID_rs2),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .PCWrite      (PCWrite),
        .IFID_Write   (IFID_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_mux_out (IDEX_mux_out),
        .IDEX_Write   (IDEX_Write),
        .EXMEM_Write  (EXMEM_Write),
        .MEMWB_Bubble (MEMWB_Bubble),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    // Control bundle order: PCWrite IFID_Write IFID_Flush IDEX_mux_out
    //                       IDEX_Write EXMEM_Write MEMWB_Bubble
    localparam logic [6:0] CTRL_NORMAL = 7'b1101110;
    localparam logic [6:0] CTRL_MEMSTL = 7'b0001001;
    localparam logic [6:0] CTRL_FLUSH  = 7'b1110110;
    localparam logic [6:0] CTRL_LDUSE  = 7'b0000110;

    logic [6:0] dut_ctrl;
    assign dut_ctrl = {PCWrite, IFID_Write, IFID_Flush, IDEX_mux_out,
                       IDEX_Write, EXMEM_Write, MEMWB_Bubble};

    // Model state in pipeline terms.
    bit m_owed_flush  = 1'b0;  // a redirect is waiting for memory to finish
    bit m_waiting     = 1'b0;  // the previous cycle was a memory stall
    int m_wait_cycles = 0;     // MEM_WAIT-state cycles in the current wait
    bit m_timeout     = 1'b0;
    int m_stalls      = 0;
    int m_flushes     = 0;

    function automatic logic [6:0] model_ctrl();
        bit mem_stall = dmem_req && !dmem_ready;
        bit hazard    = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                        ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
        if (reset)                             return CTRL_NORMAL;
        else if (mem_stall)                    return CTRL_MEMSTL;
        else if (branch_taken || m_owed_flush) return CTRL_FLUSH;
        else if (hazard)                       return CTRL_LDUSE;
        else                                   return CTRL_NORMAL;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs held through the cycle.
    always @(posedge clk) begin
        logic [6:0] c;
        bit mem_stall;
        c = model_ctrl();
        mem_stall = dmem_req && !dmem_ready;
        if (reset) begin
            m_owed_flush  <= 1'b0;
            m_waiting     <= 1'b0;
            m_wait_cycles <= 0;
            m_timeout     <= 1'b0;
            m_stalls      <= 0;
            m_flushes     <= 0;
        end else begin
            if (!c[6]) m_stalls  <= (m_stalls  < CNT_MAX) ? m_stalls + 1  : CNT_MAX;
            if (c[4])  m_flushes <= (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
            if (m_waiting) begin
                m_wait_cycles <= (m_wait_cycles < MAX_WAIT) ? m_wait_cycles + 1 : MAX_WAIT;
                if (m_wait_cycles + 1 >= MAX_WAIT) m_timeout <= 1'b1;
            end else if (mem_stall) begin
                m_wait_cycles <= 0;
            end
            m_waiting    <= mem_stall;
            m_owed_flush <= mem_stall && (m_owed_flush || branch_taken);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ctrl",        32'(dut_ctrl),    32'(model_ctrl()));
        chk("stall_cnt",   32'(stall_cnt),   32'(m_stalls));
        chk("flush_cnt",   32'(flush_cnt),   32'(m_flushes));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IDEX_MemRead = 1'b0; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        chk("reset_ctrl", 32'(dut_ctrl), 32'(CTRL_NORMAL));
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_stall_cnt", 32'(stall_cnt),   32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt),   32'd0);
        chk("reset_timeout",   32'(mem_timeout), 32'd0);
        tick();

        // Load-use on rs2: one bubble cycle.
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd3; IFID_rs2 = 5'd5;
        #1;
        chk("lu_pcwrite", 32'(PCWrite),      32'd0);
        chk("lu_ifid_wr", 32'(IFID_Write),   32'd0);
        chk("lu_mux",     32'(IDEX_mux_out), 32'd0);
        tick();
        idle();
        #1;
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_after_pc",  32'(PCWrite),   32'd1);
        tick();

        // Load into x0 never hazards.
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd0; IFID_rs1 = 5'd0;
        #1;
        chk("x0_ctrl", 32'(dut_ctrl), 32'(CTRL_NORMAL));
        tick();
        idle();

        // Memory wait: 3 stalled cycles then ready.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("mw_ctrl", 32'(dut_ctrl), 32'(CTRL_MEMSTL));
        tick(); tick(); tick();
        dmem_ready = 1'b1;
        #1;
        chk("mw_done_ctrl", 32'(dut_ctrl), 32'(CTRL_NORMAL));
        tick();
        idle();
        #1;
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        tick();

        // Branch in the 2nd wait cycle, ready on the 4th.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("bw_flush_ctrl", 32'(dut_ctrl), 32'(CTRL_FLUSH));
        tick();
        idle();
        #1;
        chk("bw_once",      32'(IFID_Flush), 32'd0);
        chk("bw_flush_cnt", 32'(flush_cnt),  32'd1);
        chk("bw_stall_cnt", 32'(stall_cnt),  32'd7);
        tick();

        // Two branches in one wait merge into a single flush.
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        tick(); tick();
        branch_taken = 1'b0;
        tick();
        dmem_ready = 1'b1;
        tick();
        idle();
        #1;
        chk("merge_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("merge_stall_cnt", 32'(stall_cnt), 32'd10);
        tick();

        // Branch together with a load-use: flush wins, no stall.
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd7; IFID_rs1 = 5'd7; branch_taken = 1'b1;
        #1;
        chk("bl_ctrl", 32'(dut_ctrl), 32'(CTRL_FLUSH));
        tick();
        idle();
        #1;
        chk("bl_stall_cnt", 32'(stall_cnt), 32'd10);
        chk("bl_flush_cnt", 32'(flush_cnt), 32'd3);

        // Watchdog: 20 stalled cycles; timeout after the 15th MEM_WAIT cycle.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("wd_not_yet", 32'(mem_timeout), 32'd0);
        tick();
        chk("wd_set", 32'(mem_timeout), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("wd_still_stalled", 32'(PCWrite), 32'd0);
        dmem_ready = 1'b1;
        tick();
        idle();
        tick();
        chk("wd_sticky",    32'(mem_timeout), 32'd1);
        chk("wd_stall_cnt", 32'(stall_cnt),   32'd30);

        // Reset in the middle of a wait with a flush pending discards both.
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'(dut_ctrl), 32'(CTRL_NORMAL));
        tick();
        reset = 1'b0; idle();
        #1;
        chk("rst_no_flush",  32'(IFID_Flush),  32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt),   32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt),   32'd0);
        chk("rst_timeout",   32'(mem_timeout), 32'd0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
